// File: rtl/ps_rr_arbiter_pkg.sv
// ps_arb_pkg: shared types and helpers for the packet-stream round-robin arbiter.
//   ps_arb_state_t : arbiter FSM state (IDLE = no grant, BUSY = grant locked to a packet)
//   clog2_min1     : index width for n channels, never less than 1 bit
package ps_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} ps_arb_state_t;

  // ceil(log2(n)), clamped to 1 so a single-channel build still has a 1-bit index
  function automatic int clog2_min1(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ps_rr_arbiter_if.sv
// ps_rr_arbiter_if: NCH inbound PacketStreams plus one outbound PacketStream.
//   i_dat/i_val/i_eop/i_rdy : inbound channels, channel k data at [k*DWIDTH +: DWIDTH]
//   o_dat/o_val/o_eop/o_rdy : shared outbound stream
//   o_chan                  : channel currently owning the outbound stream
// Modports:
//   master : environment side (drives inbound beats and outbound ready)
//   slave  : arbiter side
interface ps_rr_arbiter_if
  import ps_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4
);
  localparam int CWIDTH = clog2_min1(NCH);

  logic [NCH*DWIDTH-1:0] i_dat;
  logic [NCH-1:0]        i_val;
  logic [NCH-1:0]        i_eop;
  logic [NCH-1:0]        i_rdy;
  logic [DWIDTH-1:0]     o_dat;
  logic                  o_val;
  logic                  o_eop;
  logic                  o_rdy;
  logic [CWIDTH-1:0]     o_chan;

  modport master (
    output i_dat, i_val, i_eop, o_rdy,
    input  i_rdy, o_dat, o_val, o_eop, o_chan
  );

  modport slave (
    input  i_dat, i_val, i_eop, o_rdy,
    output i_rdy, o_dat, o_val, o_eop, o_chan
  );

endinterface

// File: rtl/ps_rr_arbiter_pick.sv
// ps_rr_pick: combinational round-robin picker.
//   i_req : request vector
//   i_ptr : search start index (must be < N)
//   o_hit : any request set
//   o_idx : first set request at or after i_ptr, wrapping N-1 -> 0
module ps_rr_pick
  import ps_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [CW-1:0] i_ptr,
  output logic          o_hit,
  output logic [CW-1:0] o_idx
);

  logic [CW:0] w_c;

  // Scan offsets from farthest to nearest so the nearest set bit is written last and wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_c = {1'b0, i_ptr} + (CW+1)'(i);
      if (w_c >= (CW+1)'(N)) w_c = w_c - (CW+1)'(N);
      if (i_req[w_c[CW-1:0]]) begin
        o_hit = 1'b1;
        o_idx = w_c[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/ps_rr_arbiter.sv
// ps_rr_arbiter: round-robin arbiter/mux sharing one outbound PacketStream among NCH inputs.
// Grant is locked from the first beat of a packet to its accepted eop; o_chan carries the
// owner for the whole packet.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ps_rr_arbiter_if.slave (inbound channels, outbound stream, o_chan)
module ps_rr_arbiter
  import ps_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4
) (
  input  logic           clk,
  input  logic           reset,
  ps_rr_arbiter_if.slave bus
);

  localparam int CWIDTH = clog2_min1(NCH);

  ps_arb_state_t            r_state, w_state_nxt;
  logic [CWIDTH-1:0]        r_grant, w_grant_nxt;
  logic [CWIDTH-1:0]        r_ptr,   w_ptr_nxt;

  logic [NCH-1:0][DWIDTH-1:0] w_dat;
  logic                       w_g_val, w_g_eop;
  logic [CWIDTH-1:0]          w_gp1;
  logic [NCH-1:0]             w_sw_req;
  logic                       w_idle_hit, w_sw_hit;
  logic [CWIDTH-1:0]          w_idle_idx, w_sw_idx;

  assign w_dat   = bus.i_dat;
  assign w_g_val = bus.i_val[r_grant];
  assign w_g_eop = bus.i_eop[r_grant];
  assign w_gp1   = (r_grant == CWIDTH'(NCH - 1)) ? '0 : r_grant + CWIDTH'(1);
  // Switch-over excludes the finishing channel so a lone streamer cannot starve the bubble rule.
  assign w_sw_req = bus.i_val & ~(NCH'(1) << r_grant);

  ps_rr_pick #(.N(NCH)) u_pick_idle (
    .i_req (bus.i_val),
    .i_ptr (r_ptr),
    .o_hit (w_idle_hit),
    .o_idx (w_idle_idx)
  );

  ps_rr_pick #(.N(NCH)) u_pick_sw (
    .i_req (w_sw_req),
    .i_ptr (w_gp1),
    .o_hit (w_sw_hit),
    .o_idx (w_sw_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // o_val depends only on state and the granted i_val; o_rdy only steers i_rdy and next state.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    bus.o_val   = 1'b0;
    bus.o_eop   = bus.i_eop[0];
    bus.o_dat   = w_dat[0];
    bus.o_chan  = r_grant;
    bus.i_rdy   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_hit) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_idle_idx;
        end
      end
      ST_BUSY: begin
        bus.o_val          = w_g_val;
        bus.o_eop          = w_g_eop;
        bus.o_dat          = w_dat[r_grant];
        bus.i_rdy[r_grant] = bus.o_rdy;
        if (w_g_val && bus.o_rdy && w_g_eop) begin
          w_ptr_nxt = w_gp1;
          if (w_sw_hit) w_grant_nxt = w_sw_idx;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps_rr_arbiter.sv
module tb_ps_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps_rr_arbiter_if #(.DWIDTH(8), .NCH(4)) bus ();

  ps_rr_arbiter #(.DWIDTH(8), .NCH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] val, input logic [3:0] eop, input logic [31:0] dat,
                       input logic rdy);
    bus.i_val = val;
    bus.i_eop = eop;
    bus.i_dat = dat;
    bus.o_rdy = rdy;
  endtask

  task automatic step(input logic [3:0] val, input logic [3:0] eop, input logic [31:0] dat,
                      input logic rdy);
    @(negedge clk);
    drive(val, eop, dat, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(4'b0, 4'b0, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  val;
    logic [3:0]  eop;
    logic [31:0] dat;
    logic        rdy;
    logic        e_val;
    logic        e_eop;
    logic [7:0]  e_dat;
    logic [1:0]  e_chan;
    logic [3:0]  e_irdy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] val, input logic [3:0] eop, input logic [31:0] dat,
                              input logic rdy, input logic e_val, input logic e_eop,
                              input logic [7:0] e_dat, input logic [1:0] e_chan,
                              input logic [3:0] e_irdy);
    vec_t v;
    v.val = val; v.eop = eop; v.dat = dat; v.rdy = rdy;
    v.e_val = e_val; v.e_eop = e_eop; v.e_dat = e_dat; v.e_chan = e_chan; v.e_irdy = e_irdy;
    return v;
  endfunction

  vec_t tbl[11];

  // test 3 / 5 state
  logic [3:0] b3;
  int         ord;
  logic [3:0] v5, e5;
  logic [31:0] d5;
  int         pk_rem[2], len_left[2], tx_cnt[2], rx_cnt[2], rx_beat[2];
  logic [5:0] seq_tx[2], seq_rx[2];
  int         len_q0[$], len_q1[$];
  logic       in_pkt;
  logic [1:0] pkt_chan;
  int         cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // packed as {ch3, ch2, ch1, ch0}
    tbl[0]  = mk(4'b0100, 4'b0000, 32'h0021_0000, 1, 0, 0, 8'h00, 2'd0, 4'b0000);
    tbl[1]  = mk(4'b0100, 4'b0000, 32'h0021_0000, 1, 1, 0, 8'h21, 2'd2, 4'b0100);
    tbl[2]  = mk(4'b0100, 4'b0000, 32'h0022_0000, 1, 1, 0, 8'h22, 2'd2, 4'b0100);
    tbl[3]  = mk(4'b0100, 4'b0100, 32'h0023_0000, 1, 1, 1, 8'h23, 2'd2, 4'b0100);
    tbl[4]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 2'd2, 4'b0000);
    tbl[5]  = mk(4'b1010, 4'b1000, 32'h3300_1100, 1, 0, 0, 8'h00, 2'd2, 4'b0000);
    tbl[6]  = mk(4'b1010, 4'b1000, 32'h3300_1100, 1, 1, 1, 8'h33, 2'd3, 4'b1000);
    tbl[7]  = mk(4'b1010, 4'b1010, 32'h3400_1100, 0, 1, 1, 8'h11, 2'd1, 4'b0000);
    tbl[8]  = mk(4'b1010, 4'b1010, 32'h3400_1100, 1, 1, 1, 8'h11, 2'd1, 4'b0010);
    tbl[9]  = mk(4'b1000, 4'b1000, 32'h3400_0000, 1, 1, 1, 8'h34, 2'd3, 4'b1000);
    tbl[10] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 8'h00, 2'd3, 4'b0000);

    // 1: reset state held for 10 cycles
    drive(4'b0, 4'b0, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("t1_o_val", bus.o_val, 0);
      chk("t1_i_rdy", bus.i_rdy, 0);
      chk("t1_o_chan", bus.o_chan, 0);
    end

    // 2: table (ch2 3-beat packet, single-beat switch-over, stall on eop)
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].val, tbl[i].eop, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("t2_v%0d_o_val", i), bus.o_val, tbl[i].e_val);
      chk($sformatf("t2_v%0d_o_eop", i), bus.o_eop, tbl[i].e_eop);
      chk($sformatf("t2_v%0d_o_dat", i), bus.o_dat, tbl[i].e_dat);
      chk($sformatf("t2_v%0d_o_chan", i), bus.o_chan, tbl[i].e_chan);
      chk($sformatf("t2_v%0d_i_rdy", i), bus.i_rdy, tbl[i].e_irdy);
    end

    // 3: all channels streaming 2-beat packets from reset
    do_reset();
    b3 = 4'b0;
    ord = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive(4'hF, b3, {4'h3, 3'b0, b3[3], 4'h2, 3'b0, b3[2], 4'h1, 3'b0, b3[1], 4'h0, 3'b0, b3[0]},
            1'b1);
      #1;
      if (c == 0) chk("t3_bubble", bus.o_val, 0);
      else begin
        chk("t3_noidle", bus.o_val, 1);
        chk("t3_chan", bus.o_chan, 32'(ord % 4));
        chk("t3_dat", bus.o_dat, 32'((ord % 4) * 16) + 32'(b3[ord % 4]));
        if (bus.o_val && bus.o_eop) ord++;
      end
      for (int k = 0; k < 4; k++) if (bus.i_rdy[k]) b3[k] = ~b3[k];
    end
    chk("t3_pkts", ord, 19);

    // 4: ch1 stalls mid-packet while ch3 waits
    do_reset();
    step(4'b0010, 4'b0000, 32'h0000_1000, 1);
    chk("t4_idle", bus.o_val, 0);
    step(4'b1010, 4'b1000, 32'h3000_1000, 1);
    chk("t4_b0_chan", bus.o_chan, 1);
    chk("t4_b0_dat", bus.o_dat, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 4'b1000, 32'h3000_0000, 1);
      chk("t4_gap_val", bus.o_val, 0);
      chk("t4_gap_chan", bus.o_chan, 1);
      chk("t4_gap_irdy", bus.i_rdy, 4'b0010);
    end
    step(4'b1010, 4'b1010, 32'h3000_1100, 1);
    chk("t4_eop_chan", bus.o_chan, 1);
    chk("t4_eop_dat", bus.o_dat, 8'h11);
    chk("t4_eop_eop", bus.o_eop, 1);
    step(4'b1000, 4'b1000, 32'h3000_0000, 1);
    chk("t4_ch3_chan", bus.o_chan, 3);
    chk("t4_ch3_val", bus.o_val, 1);
    chk("t4_ch3_dat", bus.o_dat, 8'h30);
    step(4'b0000, 4'b0000, 32'h0, 1);
    chk("t4_end_val", bus.o_val, 0);

    // 5: random o_rdy, ch0/ch3 variable-length packets, per-channel scoreboard
    do_reset();
    for (int c = 0; c < 2; c++) begin
      pk_rem[c] = 6; tx_cnt[c] = 0; rx_cnt[c] = 0; rx_beat[c] = 0;
      seq_tx[c] = '0; seq_rx[c] = '0;
      len_left[c] = $urandom_range(1, 8);
    end
    len_q0.push_back(len_left[0]);
    len_q1.push_back(len_left[1]);
    in_pkt = 1'b0;
    pkt_chan = '0;
    cyc = 0;
    while ((pk_rem[0] > 0 || pk_rem[1] > 0) && cyc < 3000) begin
      v5 = 4'b0; e5 = 4'b0; d5 = '0;
      if (pk_rem[0] > 0) begin
        v5[0] = 1'b1; e5[0] = (len_left[0] == 1); d5[7:0] = {2'd0, seq_tx[0]};
      end
      if (pk_rem[1] > 0) begin
        v5[3] = 1'b1; e5[3] = (len_left[1] == 1); d5[31:24] = {2'd3, seq_tx[1]};
      end
      @(negedge clk);
      drive(v5, e5, d5, 1'($urandom_range(0, 1)));
      #1;
      if (bus.o_val && bus.o_rdy) begin
        chk("t5_chan_ok", (bus.o_chan == 2'd0 || bus.o_chan == 2'd3), 1);
        if (bus.o_chan == 2'd0 || bus.o_chan == 2'd3) begin
          automatic int ci = (bus.o_chan == 2'd3) ? 1 : 0;
          automatic int plen = (ci == 0) ? len_q0[0] : len_q1[0];
          chk("t5_dat", bus.o_dat, {bus.o_chan, seq_rx[ci]});
          seq_rx[ci]++;
          rx_cnt[ci]++;
          rx_beat[ci]++;
          chk("t5_eop", bus.o_eop, (rx_beat[ci] == plen));
          if (in_pkt) chk("t5_chan_stable", bus.o_chan, pkt_chan);
          in_pkt = 1'b1;
          pkt_chan = bus.o_chan;
          if (rx_beat[ci] == plen) begin
            rx_beat[ci] = 0;
            in_pkt = 1'b0;
            if (ci == 0) void'(len_q0.pop_front());
            else         void'(len_q1.pop_front());
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (v5[c*3] && bus.i_rdy[c*3]) begin
          seq_tx[c]++;
          tx_cnt[c]++;
          len_left[c]--;
          if (len_left[c] == 0) begin
            pk_rem[c]--;
            if (pk_rem[c] > 0) begin
              len_left[c] = $urandom_range(1, 8);
              if (c == 0) len_q0.push_back(len_left[c]);
              else        len_q1.push_back(len_left[c]);
            end
          end
        end
      end
      cyc++;
    end
    chk("t5_timeout", (cyc < 3000), 1);
    chk("t5_cnt_ch0", rx_cnt[0], tx_cnt[0]);
    chk("t5_cnt_ch3", rx_cnt[1], tx_cnt[1]);
    chk("t5_rx_pkts_open", in_pkt, 0);

    // 6: reset in the middle of a ch2 packet, ptr must return to 0
    do_reset();
    step(4'b0010, 4'b0010, 32'h0000_1000, 1);
    chk("t6_idle", bus.o_val, 0);
    step(4'b0110, 4'b0010, 32'h0020_1000, 1);
    chk("t6_ch1_chan", bus.o_chan, 1);
    chk("t6_ch1_eop", bus.o_eop, 1);
    step(4'b0100, 4'b0000, 32'h0020_0000, 1);
    chk("t6_ch2_chan", bus.o_chan, 2);
    chk("t6_ch2_dat", bus.o_dat, 8'h20);
    step(4'b0100, 4'b0000, 32'h0021_0000, 1);
    chk("t6_ch2_val", bus.o_val, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_val", bus.o_val, 0);
    chk("t6_rst_irdy", bus.i_rdy, 0);
    chk("t6_rst_chan", bus.o_chan, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0101, 4'b0000, 32'h0020_0001, 1);
    #1;
    chk("t6_post_idle", bus.o_val, 0);
    step(4'b0101, 4'b0000, 32'h0020_0001, 1);
    chk("t6_post_chan", bus.o_chan, 0);
    chk("t6_post_val", bus.o_val, 1);
    chk("t6_post_dat", bus.o_dat, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
